button_bank: RTL and testbench



---
 rtl/ghffe_input_pkg.sv | 15 +
 rtl/button_channel.sv | 140 ++++++++++++++
 rtl/button_bank.sv | 50 +++++
 tb/tb_button_bank.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/ghffe_input_pkg.sv
// Shared definitions for the button input path: channel states and default
// timing constants at 100 MHz.
package ghffe_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } chan_state_t;

  localparam int DEBOUNCE_10MS = 1000000;
  localparam int HOLD_500MS    = 50000000;
  localparam int REPEAT_100MS  = 10000000;

endpackage : ghffe_input_pkg

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// pulses and hold/auto-repeat FSM (repeat built only with BUTTON_BANK_AUTO_REPEAT_EN).
module button_channel
  import ghffe_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic clock,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic press,
  output logic release_pulse,
  output logic held,
  output logic hold_pulse,
  output logic repeat_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [1:0]        sync_reg;
  logic [DB_W-1:0]   db_cnt_reg, db_cnt_next;
  logic              clean_reg;
  logic              press_reg, release_reg, hold_pulse_reg;
  chan_state_t       state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              db_toggle, rise, fall, hold_entry;

  assign db_toggle = (db_cnt_reg == DB_MAX);
  assign rise      = db_toggle & ~clean_reg;
  assign fall      = db_toggle &  clean_reg;

  // Counter only runs while the synchronised level disagrees with clean.
  always_comb begin
    db_cnt_next = '0;
    if ((sync_reg[1] != clean_reg) && !db_toggle)
      db_cnt_next = db_cnt_reg + 1'b1;
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    hold_entry    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        hold_cnt_next = '0;
        if (rise) state_next = ST_PRESSED;
      end
      ST_PRESSED: begin
        // A fall on the threshold cycle wins: short press, no hold.
        if (fall) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next = ST_HELD;
          hold_entry = 1'b1;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      ST_HELD: begin
        if (fall) begin
          state_next    = ST_IDLE;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_reg       <= '0;
      db_cnt_reg     <= '0;
      clean_reg      <= 1'b0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
      hold_pulse_reg <= 1'b0;
      state_reg      <= ST_IDLE;
      hold_cnt_reg   <= '0;
    end else begin
      sync_reg       <= {sync_reg[0], noisy};
      db_cnt_reg     <= db_cnt_next;
      clean_reg      <= clean_reg ^ db_toggle;
      press_reg      <= rise;
      release_reg    <= fall;
      hold_pulse_reg <= hold_entry;
      state_reg      <= state_next;
      hold_cnt_reg   <= hold_cnt_next;
    end
  end

`ifdef BUTTON_BANK_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             repeat_reg, rpt_fire;
  logic             in_held;

  assign in_held  = (state_reg == ST_HELD) && !fall;
  assign rpt_fire = hold_entry | (in_held && (rpt_cnt_reg == RPT_LAST));

  // Counter restarts at hold entry and after every repeat, idles at 0 elsewhere.
  always_comb begin
    rpt_cnt_next = '0;
    if (in_held && (rpt_cnt_reg != RPT_LAST))
      rpt_cnt_next = rpt_cnt_reg + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rpt_cnt_reg <= '0;
      repeat_reg  <= 1'b0;
    end else begin
      rpt_cnt_reg <= rpt_cnt_next;
      repeat_reg  <= rpt_fire;
    end
  end

  assign repeat_pulse = repeat_reg;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign clean         = clean_reg;
  assign press         = press_reg;
  assign release_pulse = release_reg;
  assign hold_pulse    = hold_pulse_reg;
  assign held          = (state_reg == ST_HELD);

endmodule : button_channel

// File: rtl/button_bank.sv
// NUM_BTNS independent button channels. Optional auto-repeat: BUTTON_BANK_AUTO_REPEAT_EN.
// release/repeat are SV keywords, so those ports are release_pulse/repeat_pulse.
module button_bank
  import ghffe_input_pkg::*;
#(
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int HOLD_CYCLES     = HOLD_500MS,
  parameter int REPEAT_CYCLES   = REPEAT_100MS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] noisy,
  output logic [NUM_BTNS-1:0] clean,
  output logic [NUM_BTNS-1:0] press,
  output logic [NUM_BTNS-1:0] release_pulse,
  output logic [NUM_BTNS-1:0] held,
  output logic [NUM_BTNS-1:0] hold_pulse,
  output logic [NUM_BTNS-1:0] repeat_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_bank: DEBOUNCE_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_bank: HOLD_CYCLES must be at least 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_bank: REPEAT_CYCLES must be at least 1");
  end

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_chan (
      .clock        (clock),
      .reset        (reset),
      .noisy        (noisy[gi]),
      .clean        (clean[gi]),
      .press        (press[gi]),
      .release_pulse(release_pulse[gi]),
      .held         (held[gi]),
      .hold_pulse   (hold_pulse[gi]),
      .repeat_pulse (repeat_pulse[gi])
    );
  end

endmodule : button_bank

// File: tb/tb_button_bank.sv
// Scoreboard bench for button_bank: per-cycle expected output vectors are
// queued as stimulus is driven and compared one cycle later.
module tb_button_bank;

  localparam int N = 5;

  logic         clock;
  logic         reset;
  logic [N-1:0] noisy;
  logic [N-1:0] clean, press, release_pulse, held, hold_pulse, repeat_pulse;

  typedef struct packed {
    logic [N-1:0] clean;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] held;
    logic [N-1:0] hp;
    logic [N-1:0] rpt;
  } out_t;

  out_t obs;
  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  button_bank #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .noisy        (noisy),
    .clean        (clean),
    .press        (press),
    .release_pulse(release_pulse),
    .held         (held),
    .hold_pulse   (hold_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb obs = {clean, press, release_pulse, held, hold_pulse, repeat_pulse};

  task automatic check_vec(input string tag, input out_t got, input out_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end else begin
      $display("vec %s: out=%h ok", tag, got);
    end
  endtask

  // Expected outputs after edge c, taken directly from the timing plan.
  function automatic out_t expect_at(input int sc, input int c);
    out_t e;
    e = '0;
    case (sc)
      0: begin
        e.clean[0] = (c >= 6);
        e.press[0] = (c == 6);
      end
      2: begin
        e.clean[2] = (c >= 6) && (c < 32);
        e.press[2] = (c == 6);
        e.rel[2]   = (c == 32);
        e.held[2]  = (c >= 16) && (c < 32);
        e.hp[2]    = (c == 16);
`ifdef BUTTON_BANK_AUTO_REPEAT_EN
        e.rpt[2]   = (c >= 16) && (c < 32) && (((c - 16) % 3) == 0);
`endif
      end
      3: begin
        e.clean[3] = (c >= 6) && (c < 16);
        e.press[3] = (c == 6);
        e.rel[3]   = (c == 16);
      end
      4: begin
        e.clean[0] = ((c >= 6) && (c <= 8)) || (c >= 16);
        e.clean[4] = e.clean[0];
        e.press[0] = (c == 6) || (c == 16);
        e.press[4] = e.press[0];
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [N-1:0] noisy_at(input int sc, input int c);
    logic [N-1:0] n;
    n = '0;
    case (sc)
      0: n[0] = 1'b1;
      1: n[1] = (c <= 2);
      2: n[2] = (c <= 25);
      3: n[3] = (c <= 9);
      4: begin n[0] = 1'b1; n[4] = 1'b1; end
      default: n = '0;
    endcase
    return n;
  endfunction

  task automatic run_scenario(input int sc, input int last_cycle);
    out_t want;
    // Fresh start: reset held for two edges, outputs must read zero.
    noisy = '0;
    reset = 1'b0;
    @(posedge clock);
    exp_q.push_back('0);
    @(posedge clock);
    #1;
    want = exp_q.pop_front();
    check_vec($sformatf("s%0d reset", sc), obs, want);
    for (int c = 0; c <= last_cycle; c++) begin
      noisy = noisy_at(sc, c);
      reset = !((sc == 4) && (c == 9));
      exp_q.push_back(expect_at(sc, c));
      @(posedge clock);
      #1;
      want = exp_q.pop_front();
      check_vec($sformatf("s%0d c%0d", sc, c), obs, want);
    end
  endtask

  initial begin
    noisy = '0;
    reset = 1'b0;
    #1;
    run_scenario(0, 12);   // clean press on channel 0
    run_scenario(1, 15);   // 3-cycle glitch on channel 1
    run_scenario(2, 36);   // long press with hold and repeat on channel 2
    run_scenario(3, 24);   // short press released on the hold threshold
    run_scenario(4, 20);   // simultaneous press, reset mid-press
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_button_bank
